// File: rtl/com_pktpack.sv
// ----------------------------------------------------------------------------
// com_pktpack
//   Packs an 8-bit byte stream framed by sop/eop into words of BPW bytes and
//   stores them in a store-and-forward packet buffer. A reader only sees a
//   packet after its eop word has been written (committed).
//   The first byte of a word sits in the MSB lane. Lanes past the last byte
//   of a packet are zero.
//
//   Parameters : BPW bytes per word (1,2,4,8), AW buffer address width,
//                MW width of out_mod (2**MW > BPW)
//   Ports      : clk, rst (async, active-low)
//                in_dval/in_sop/in_eop/in_data  byte stream in
//                mm_rdreq                       read request
//                out_empty                      no committed word available
//                out_dval/out_data/out_mod      registered read word
//                                               out_data = {sop, eop, word}
//                pkt_cnt/drop_cnt               saturating packet statistics
//   Macro      : COM_PKTPACK_STAT_EN builds the statistics counters; without
//                it pkt_cnt and drop_cnt are tied to zero.
// ----------------------------------------------------------------------------
module com_pktpack #(
    parameter int BPW = 2,
    parameter int AW  = 10,
    parameter int MW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_dval,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [7:0]         in_data,
    input  logic               mm_rdreq,
    output logic               out_empty,
    output logic               out_dval,
    output logic [8*BPW+1:0]   out_data,
    output logic [MW-1:0]      out_mod,
    output logic [15:0]        pkt_cnt,
    output logic [15:0]        drop_cnt
);

    localparam int WW    = 8 * BPW;
    localparam int PW    = AW + 1;
    localparam int DW    = WW + MW + 2;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, PACK, DROP} state_t;

    state_t            state;
    logic [WW-1:0]     lane_buf;
    logic [MW-1:0]     lane_idx;
    logic              first_pend;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     commit_ptr;

    // Staged word write and commit: both land one cycle after the last byte.
    logic              wq_en;
    logic [AW-1:0]     wq_addr;
    logic [DW-1:0]     wq_data;
    logic              cq_en;
    logic [PW-1:0]     cq_ptr;

    // Stored word layout: {sop, eop, mod, bytes}
    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     rd_word;

    logic              start;
    logic              cont;
    logic              abort;
    logic [PW-1:0]     eff_commit;
    logic [PW-1:0]     waddr;
    logic [MW-1:0]     lane;
    logic [MW-1:0]     fill;
    logic              word_done;
    logic              full;
    logic              sop_flag;
    logic              rd_en;
    logic [WW-1:0]     asm_word;

    assign start      = in_dval & in_sop;
    assign cont       = in_dval & ~in_sop & (state == PACK);
    assign abort      = start & (state == PACK);
    // A commit may still be staged; rewinds must land on the newest commit.
    assign eff_commit = cq_en ? cq_ptr : commit_ptr;
    assign waddr      = abort ? eff_commit : wr_ptr;
    assign lane       = start ? '0 : lane_idx;
    assign fill       = lane + MW'(1);
    assign word_done  = (start | cont) & ((fill == MW'(BPW)) | in_eop);
    // Pointers carry one extra wrap bit, so a difference of DEPTH means every
    // slot holds an unread word and this write would overwrite one.
    assign full       = ((waddr - rd_ptr) == PW'(DEPTH));
    assign sop_flag   = start | first_pend;

    assign out_empty  = (rd_ptr == commit_ptr);
    assign rd_en      = mm_rdreq & ~out_empty;
    assign rd_word    = mem[rd_ptr[AW-1:0]];

    // Merge the incoming byte into its lane; a new packet starts from a
    // clean word so stale lanes of an aborted packet never leak through.
    always_comb begin
        asm_word = start ? '0 : lane_buf;
        for (int k = 0; k < BPW; k++) begin
            if (MW'(k) == lane) begin
                asm_word[8*(BPW-1-k) +: 8] = in_data;
            end
        end
    end

    // Buffer storage has no reset; only committed words are ever read.
    always_ff @(posedge clk) begin
        if (wq_en) begin
            mem[wq_addr] <= wq_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lane_buf   <= '0;
            lane_idx   <= '0;
            first_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            commit_ptr <= '0;
            wq_en      <= 1'b0;
            wq_addr    <= '0;
            wq_data    <= '0;
            cq_en      <= 1'b0;
            cq_ptr     <= '0;
            out_dval   <= 1'b0;
            out_data   <= '0;
            out_mod    <= '0;
        end else begin
            wq_en <= 1'b0;
            cq_en <= 1'b0;
            if (cq_en) begin
                commit_ptr <= cq_ptr;
            end

            // Read side uses the pre-commit empty flag.
            out_dval <= rd_en;
            if (rd_en) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_data <= {rd_word[DW-1 -: 2], rd_word[WW-1:0]};
                out_mod  <= rd_word[WW +: MW];
            end

            if (start | cont) begin
                if (word_done) begin
                    lane_buf   <= '0;
                    lane_idx   <= '0;
                    first_pend <= 1'b0;
                    if (full) begin
                        wr_ptr <= eff_commit;
                        state  <= DROP;
                    end else begin
                        wq_en   <= 1'b1;
                        wq_addr <= waddr[AW-1:0];
                        wq_data <= {sop_flag, in_eop, fill, asm_word};
                        wr_ptr  <= waddr + PW'(1);
                        if (in_eop) begin
                            cq_en  <= 1'b1;
                            cq_ptr <= waddr + PW'(1);
                            state  <= IDLE;
                        end else begin
                            state  <= PACK;
                        end
                    end
                end else begin
                    lane_buf   <= asm_word;
                    lane_idx   <= fill;
                    first_pend <= sop_flag;
                    wr_ptr     <= waddr;
                    state      <= PACK;
                end
            end else if (in_dval && in_eop && state == DROP) begin
                state <= IDLE;
            end
        end
    end

`ifdef COM_PKTPACK_STAT_EN
    logic        ovf;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    // An abort and an overflow of the restarted packet can coincide.
    assign ovf      = word_done & full;
    assign drop_inc = {1'b0, abort} + {1'b0, ovf};
    assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (cq_en && pkt_cnt != 16'hFFFF) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    assign pkt_cnt  = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule
